alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Operand-fetch, issue and writeback stage that sits directly upstream of the combinational ALU.
- Accepts one 16-bit instruction through a valid/ready handshake and decodes it.
- Reads two operands from an internal 8-entry register file and drives the ALU's A, B and opcode inputs for exactly one cycle.
- Captures the ALU result, writes it back to the destination register and reports completion.

Parameters:
- N, 16, data width of registers, ALU operands and result.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  upstream has an instruction on instr.
- instr_ready  output  1  stage can accept an instruction this cycle.
- instr  input  16  instruction word.
- alu_a  output  N  ALU operand A.
- alu_b  output  N  ALU operand B.
- alu_op  output  4  ALU opcode: 0 ADD, 1 XOR, 2 OR, 3 AND, 4 SEQ, 5 SLT, 6 SL, 7 SR.
- alu_out  input  N  combinational ALU result.
- done  output  1  one-cycle pulse; the instruction has retired.
- result  output  N  written-back value; valid while done=1.
- dbg_addr  input  3  debug register-file read address.
- dbg_data  output  N  combinational read of reg[dbg_addr]; r0 reads 0.

Behaviour:
- Instruction format:
  - [15] I: 1 = immediate form.
  - [14:12] op: sent as alu_op = {1'b0, op}.
  - [11:9] rd.
  - [8:6] rs1.
  - I=0: [5:3] rs2, [2:0] ignored.
  - I=1: [5:0] imm6, sign-extended to N.
- Register file:
  - 8 x N registers; r0 always reads 0; writes to r0 are discarded.
  - All registers reset to 0.
- FSM states IDLE, EXEC, WB:
  - IDLE: instr_ready=1. When instr_valid=1, latch instr and go to EXEC; otherwise stay in IDLE.
  - EXEC (exactly 1 cycle): alu_a=reg[rs1]; alu_b = I ? sext(imm6) : reg[rs2]; alu_op=op. On the exiting edge, sample alu_out into result and write it to reg[rd] (skipped when rd=0). Go to WB.
  - WB (exactly 1 cycle): done=1, result holds the captured value. Go to IDLE.
- Timing:
  - instr_ready=0 in EXEC and WB, so upstream must hold instr/instr_valid until the handshake.
  - Throughput: 1 instruction per 3 cycles.
  - Latency: handshake edge to done = 2 edges.
- ALU output drive: outside EXEC, alu_a, alu_b and alu_op are 0 (a benign ADD 0+0).
- Operand read timing:
  - Operands are read in EXEC from the current register contents.
  - A back-to-back instruction sees the previous write, since the write completes before the next EXEC.
  - Same-register sources and destination (e.g. rd=rs1=rs2) are legal.
- Arithmetic: ADD wraps modulo 2^N. SEQ/SLT results are 0 or 1 as produced by the ALU; the stage does not modify alu_out.
- Reset:
  - Asserting rst_n low at any time forces IDLE immediately, zeroes all registers and result, and drives done=0, alu_* = 0.
  - instr_ready=0 while rst_n=0.
  - An instruction in flight is aborted with no writeback and no done.
- Debug port: dbg_data is combinational, reflects writes from the cycle after the write edge, and is unaffected by the FSM.

Test Plan:
- Reset and r0 handling: release reset; instr_ready=1; dbg_data=0 for all addresses. Issue ADDI r0,r0,#5 -> done pulses with result=5; dbg r0 still 0.
- Immediate then register add: ADDI r1,r0,#7; ADDI r2,r0,#-3 -> r2=0xFFFD. Then ADD r3,r1,r2 -> result=4; alu_a=7, alu_b=0xFFFD, alu_op=0 seen in the EXEC cycle.
- Back-to-back with instr_valid held high: 3 instructions -> instr_ready pulses every 3rd cycle; each done occurs 2 edges after its handshake; r1=7, r2=14, r3=28 for the sequence ADDI r1,#7; ADD r2,r1,r1; ADD r3,r2,r2.
- Compare and shift with r1=7, r2=14: SLT r4,r1,r2 -> 1; SEQ r5,r1,r1 -> 1; SL r6,r1,#2 (I=1) -> 28.
- Reset mid-operation: handshake ADDI r1,#9, assert rst_n low during EXEC -> no done, r1=0 after release, instr_ready=0 during reset then 1.
- Handshake hold: instr_valid=0 for 5 cycles -> state stays IDLE, alu_* = 0, no done, registers unchanged.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Operand-fetch / issue / writeback stage in front of a combinational ALU.
// One instruction per three cycles: IDLE accepts, EXEC drives the ALU, WB retires.
module alu_issue_stage #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_out,
  output logic         done,
  output logic [N-1:0] result,
  input  logic [2:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [N-1:0]      result_q, result_d;
  logic [7:0][N-1:0] regs_q, regs_d;

  logic         imm_f;
  logic [2:0]   op, rd, rs1, rs2;
  logic [N-1:0] imm_sext;

  assign imm_f    = instr_q[15];
  assign op       = instr_q[14:12];
  assign rd       = instr_q[11:9];
  assign rs1      = instr_q[8:6];
  assign rs2      = instr_q[5:3];
  assign imm_sext = {{(N-6){instr_q[5]}}, instr_q[5:0]};

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    result_d    = result_q;
    regs_d      = regs_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = 4'd0;
    case (state_q)
      IDLE: begin
        // Gate with rst_n so upstream never sees ready while held in reset.
        instr_ready = rst_n;
        if (instr_valid) begin
          instr_d = instr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_a    = regs_q[rs1];
        alu_b    = imm_f ? imm_sext : regs_q[rs2];
        alu_op   = {1'b0, op};
        result_d = alu_out;
        if (rd != 3'd0) regs_d[rd] = alu_out;
        state_d  = WB;
      end
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // r0 is hardwired to zero.
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      result_q <= '0;
      regs_q   <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      regs_q   <= regs_d;
    end
  end

  assign result   = result_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU + register-file model, directed and random instructions.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [15:0] alu_a, alu_b, alu_out, result, dbg_data;
  logic [3:0]  alu_op;
  logic        done;
  logic [2:0]  dbg_addr = '0;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] mregs [8];

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a ^ b;
      4'd2: return a | b;
      4'd3: return a & b;
      4'd4: return {15'd0, a == b};
      4'd5: return {15'd0, $signed(a) < $signed(b)};
      4'd6: return a << b[3:0];
      4'd7: return a >> b[3:0];
      default: return 16'd0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_op, alu_a, alu_b);

  alu_issue_stage #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .done(done), .result(result), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk_r(logic [2:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2);
    return {1'b0, op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] mk_i(logic [2:0] op, logic [2:0] rd, logic [2:0] rs1, logic [5:0] imm);
    return {1'b1, op, rd, rs1, imm};
  endfunction

  // Issue one instruction from IDLE and check every cycle through retirement.
  // Leaves instr_valid high; caller lowers it before the next edge if needed.
  task automatic issue(input logic [15:0] ins);
    logic [2:0]  op, rd, rs1, rs2;
    logic [15:0] a, b, r;
    op  = ins[14:12]; rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3];
    a   = mregs[rs1];
    b   = ins[15] ? {{10{ins[5]}}, ins[5:0]} : mregs[rs2];
    r   = alu_f({1'b0, op}, a, b);
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    chk("idle_ready", instr_ready, 1);
    @(posedge clk); #1;
    chk("exec_a", alu_a, a);
    chk("exec_b", alu_b, b);
    chk("exec_op", alu_op, {1'b0, op});
    chk("exec_ready", instr_ready, 0);
    chk("exec_done", done, 0);
    dbg_addr = rd;
    if (rd != 3'd0) mregs[rd] = r;
    @(posedge clk); #1;
    chk("wb_done", done, 1);
    chk("wb_result", result, r);
    chk("wb_ready", instr_ready, 0);
    chk("wb_alu_a", alu_a, 0);
    chk("wb_alu_b", alu_b, 0);
    chk("wb_alu_op", alu_op, 0);
    chk("wb_dbg_rd", dbg_data, mregs[rd]);
    @(posedge clk); #1;
    chk("post_done", done, 0);
    chk("post_ready", instr_ready, 1);
  endtask

  task automatic dbg_chk(input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk("dbg_const", dbg_data, exp);
  endtask

  task automatic rf_sweep();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("rf_sweep", dbg_data, mregs[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ins;
    for (int i = 0; i < 8; i++) mregs[i] = '0;

    // Reset state
    #12;
    chk("rst_ready", instr_ready, 0);
    chk("rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rel_ready", instr_ready, 1);
    chk("rel_result", result, 0);
    rf_sweep();

    // r0 handling
    issue(mk_i(3'd0, 3'd0, 3'd0, 6'd5));
    instr_valid = 1'b0;
    chk("r0_result", result, 16'd5);
    dbg_chk(3'd0, 16'd0);

    // Immediate then register add
    issue(mk_i(3'd0, 3'd1, 3'd0, 6'd7)); instr_valid = 1'b0;
    issue(mk_i(3'd0, 3'd2, 3'd0, 6'h3D)); instr_valid = 1'b0;
    dbg_chk(3'd2, 16'hFFFD);
    issue(mk_r(3'd0, 3'd3, 3'd1, 3'd2)); instr_valid = 1'b0;
    dbg_chk(3'd3, 16'd4);

    // Back-to-back with instr_valid held high
    issue(mk_i(3'd0, 3'd1, 3'd0, 6'd7));
    issue(mk_r(3'd0, 3'd2, 3'd1, 3'd1));
    issue(mk_r(3'd0, 3'd3, 3'd2, 3'd2));
    instr_valid = 1'b0;
    dbg_chk(3'd1, 16'd7);
    dbg_chk(3'd2, 16'd14);
    dbg_chk(3'd3, 16'd28);

    // Compare and shift
    issue(mk_r(3'd5, 3'd4, 3'd1, 3'd2)); instr_valid = 1'b0;
    issue(mk_r(3'd4, 3'd5, 3'd1, 3'd1)); instr_valid = 1'b0;
    issue(mk_i(3'd6, 3'd6, 3'd1, 6'd2)); instr_valid = 1'b0;
    dbg_chk(3'd4, 16'd1);
    dbg_chk(3'd5, 16'd1);
    dbg_chk(3'd6, 16'd28);

    // Handshake hold: nothing moves while instr_valid is low
    instr = mk_i(3'd0, 3'd7, 3'd0, 6'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_ready", instr_ready, 1);
      chk("hold_done", done, 0);
      chk("hold_alu_a", alu_a, 0);
      chk("hold_alu_b", alu_b, 0);
      chk("hold_alu_op", alu_op, 0);
    end
    rf_sweep();

    // Reset during EXEC aborts the instruction
    @(negedge clk);
    instr = mk_i(3'd0, 3'd1, 3'd0, 6'd9);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    chk("ab_exec_b", alu_b, 16'd9);
    instr_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("ab_ready", instr_ready, 0);
    chk("ab_done", done, 0);
    chk("ab_alu_b", alu_b, 0);
    chk("ab_result", result, 0);
    @(posedge clk); #1;
    chk("ab_done2", done, 0);
    chk("ab_ready2", instr_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    #1;
    chk("ab_rel_ready", instr_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("ab_no_done", done, 0);
    end
    dbg_chk(3'd1, 16'd0);
    rf_sweep();

    // Random instructions, random valid gaps
    for (int n = 0; n < 80; n++) begin
      ins = 16'($urandom);
      if ((n % 4) == 0) ins[14:12] = 3'($urandom_range(0, 3));
      issue(ins);
      if ($urandom_range(0, 2) == 0) begin
        instr_valid = 1'b0;
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          @(posedge clk); #1;
          chk("gap_done", done, 0);
          chk("gap_alu_op", alu_op, 0);
        end
      end
    end
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rf_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
